// File: rtl/timer_cmp_bank.sv
// timer_cmp_bank
// Multi-channel compare/interrupt bank driven by the timer's 64-bit counter.
// Each channel owns a 64-bit compare value, a 32-bit reload period, a control
// register (en / int_en / mode) and sticky W1C status + missed flags. A
// channel fires once on the rising edge of (cnt_val == CMP); in periodic mode
// the compare value then advances by PER, in one-shot mode en self-clears.
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   wr_en, rd_en       : decoded APB write / read strobes
//   tim_paddr          : byte address (channel n window at BASE_ADDR + n*0x20)
//   tim_pwdata         : write data
//   tim_pstrb          : byte strobes
//   tim_prdata         : combinational read data for tim_paddr
//   cnt_val            : live 64-bit counter value
//   reg_error_flag     : high while an illegal write is presented (write dropped)
//   ch_int             : per-channel interrupt (status & int_en)
//   tim_int            : OR of ch_int
module timer_cmp_bank #(
  parameter int          NUM_CH    = 4,
  parameter logic [11:0] BASE_ADDR = 12'h100
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [11:0]       tim_paddr,
  input  logic [31:0]       tim_pwdata,
  input  logic [3:0]        tim_pstrb,
  output logic [31:0]       tim_prdata,
  input  logic [63:0]       cnt_val,
  output logic              reg_error_flag,
  output logic [NUM_CH-1:0] ch_int,
  output logic              tim_int
);

  localparam logic [11:0] SUM_ADDR = BASE_ADDR - 12'h010;
  // Window region always spans eight channel slots so that accesses to
  // slots beyond NUM_CH can be recognised and rejected.
  localparam logic [12:0] WIN_END  = {1'b0, BASE_ADDR} + 13'h100;
  localparam logic [3:0]  NUM_CH_C = 4'(NUM_CH);

  logic [11:0] rel_addr;
  logic        in_win;
  logic [2:0]  win_ch;
  logic [2:0]  win_word;
  logic        ch_valid;
  logic        wr_ok;

  assign rel_addr = tim_paddr - BASE_ADDR;
  assign in_win   = ({1'b0, tim_paddr} >= {1'b0, BASE_ADDR}) && ({1'b0, tim_paddr} < WIN_END);
  assign win_ch   = rel_addr[7:5];
  assign win_word = rel_addr[4:2];
  assign ch_valid = ({1'b0, win_ch} < NUM_CH_C);

  // Reads are side-effect free and the low rel_addr bits carry no decode.
  logic unused_ok;
  assign unused_ok = &{1'b0, rd_en, rel_addr[11:8], rel_addr[1:0]};

  // Per-channel state gathered for readback and error checks.
  logic [NUM_CH-1:0][63:0] cmp_all;
  logic [NUM_CH-1:0][31:0] per_all;
  logic [NUM_CH-1:0][2:0]  ctrl_all;
  logic [NUM_CH-1:0][1:0]  stat_all;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Registers of the addressed channel.
  logic [63:0] sel_cmp;
  logic [31:0] sel_per;
  logic [2:0]  sel_ctrl;
  logic [1:0]  sel_stat;

  always_comb begin
    sel_cmp  = '0;
    sel_per  = '0;
    sel_ctrl = '0;
    sel_stat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_ch == 3'(i)) begin
        sel_cmp  = cmp_all[i];
        sel_per  = per_all[i];
        sel_ctrl = ctrl_all[i];
        sel_stat = stat_all[i];
      end
    end
  end

  // Values the addressed CTRL / PER would take if the write were accepted.
  logic [2:0]  ctrl_wr_val;
  logic [31:0] per_wr_val;
  assign ctrl_wr_val = tim_pstrb[0] ? tim_pwdata[2:0] : sel_ctrl;
  assign per_wr_val  = strb_merge(sel_per, tim_pwdata, tim_pstrb);

  // A periodic channel with PER==0 would never advance, so such writes are refused.
  always_comb begin
    reg_error_flag = 1'b0;
    if (wr_en && in_win) begin
      if (!ch_valid || (win_word >= 3'd5)) begin
        reg_error_flag = 1'b1;
      end else if ((win_word == 3'd3) && ctrl_wr_val[0] && ctrl_wr_val[2] && (sel_per == 32'd0)) begin
        reg_error_flag = 1'b1;
      end else if ((win_word == 3'd2) && (per_wr_val == 32'd0) && sel_ctrl[0] && sel_ctrl[2]) begin
        reg_error_flag = 1'b1;
      end
    end
  end

  assign wr_ok = wr_en && in_win && ch_valid && !reg_error_flag;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [63:0] cmp_reg, cmp_next;
      logic [31:0] per_reg, per_next;
      logic [2:0]  ctrl_reg, ctrl_next;
      logic        status_reg, status_next;
      logic        missed_reg, missed_next;
      logic        match_q_reg;
      logic        match, event_hit;
      logic        wr_sel, wr_lo, wr_hi, wr_per, wr_ctrl, wr_stat;
      logic        clr_status, clr_missed;

      assign wr_sel  = wr_ok && (win_ch == 3'(gi));
      assign wr_lo   = wr_sel && (win_word == 3'd0);
      assign wr_hi   = wr_sel && (win_word == 3'd1);
      assign wr_per  = wr_sel && (win_word == 3'd2);
      assign wr_ctrl = wr_sel && (win_word == 3'd3);
      assign wr_stat = wr_sel && (win_word == 3'd4);

      assign clr_status = wr_stat && tim_pstrb[0] && tim_pwdata[0];
      assign clr_missed = wr_stat && tim_pstrb[0] && tim_pwdata[1];

      // Edge-detect the match so a counter stalled on CMP fires only once.
      assign match     = (cnt_val == cmp_reg);
      assign event_hit = ctrl_reg[0] && match && !match_q_reg;

      always_comb begin
        cmp_next    = cmp_reg;
        per_next    = per_reg;
        ctrl_next   = ctrl_reg;
        // A software CMP write in the event cycle cancels the reload for both halves.
        if (wr_lo || wr_hi) begin
          if (wr_lo) cmp_next[31:0]  = strb_merge(cmp_reg[31:0], tim_pwdata, tim_pstrb);
          if (wr_hi) cmp_next[63:32] = strb_merge(cmp_reg[63:32], tim_pwdata, tim_pstrb);
        end else if (event_hit && ctrl_reg[2]) begin
          cmp_next = cmp_reg + {32'd0, per_reg};
        end
        if (wr_per) per_next = per_wr_val;
        // Software CTRL write takes priority over the one-shot self-disable.
        if (wr_ctrl) begin
          ctrl_next = ctrl_wr_val;
        end else if (event_hit && !ctrl_reg[2]) begin
          ctrl_next[0] = 1'b0;
        end
        // Set beats clear; a status clear in the event cycle also absorbs the overrun.
        status_next = event_hit || (status_reg && !clr_status);
        missed_next = (event_hit && status_reg && !clr_status) || (missed_reg && !clr_missed);
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          cmp_reg     <= '1;
          per_reg     <= '0;
          ctrl_reg    <= '0;
          status_reg  <= 1'b0;
          missed_reg  <= 1'b0;
          match_q_reg <= 1'b0;
        end else begin
          cmp_reg     <= cmp_next;
          per_reg     <= per_next;
          ctrl_reg    <= ctrl_next;
          status_reg  <= status_next;
          missed_reg  <= missed_next;
          match_q_reg <= match;
        end
      end

      assign ch_int[gi]   = status_reg && ctrl_reg[1];
      assign cmp_all[gi]  = cmp_reg;
      assign per_all[gi]  = per_reg;
      assign ctrl_all[gi] = ctrl_reg;
      assign stat_all[gi] = {missed_reg, status_reg};
    end
  endgenerate

  assign tim_int = |ch_int;

  always_comb begin
    tim_prdata = '0;
    if (tim_paddr[11:2] == SUM_ADDR[11:2]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tim_prdata[i] = stat_all[i][0];
      end
    end else if (in_win && ch_valid) begin
      case (win_word)
        3'd0:    tim_prdata = sel_cmp[31:0];
        3'd1:    tim_prdata = sel_cmp[63:32];
        3'd2:    tim_prdata = sel_per;
        3'd3:    tim_prdata = {29'd0, sel_ctrl};
        3'd4:    tim_prdata = {30'd0, sel_stat};
        default: tim_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmp_bank.sv
// Testbench for timer_cmp_bank: directed register/counter sequences; every
// stimulus pushes its expected response into a scoreboard queue, and a
// monitor on the falling clock edge pops and compares whenever the DUT is
// presenting an observable result (write -> error flag, read -> read data,
// probe -> {tim_int, ch_int}).
module tb_timer_cmp_bank;

  localparam int NUM_CH = 4;
  localparam int K_ERR  = 0;
  localparam int K_RD   = 1;
  localparam int K_INT  = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [11:0]       tim_paddr = '0;
  logic [31:0]       tim_pwdata = '0;
  logic [3:0]        tim_pstrb = '0;
  logic [31:0]       tim_prdata;
  logic [63:0]       cnt_val = '0;
  logic              reg_error_flag;
  logic [NUM_CH-1:0] ch_int;
  logic              tim_int;

  logic              probe = 1'b0;
  logic [63:0]       cnt_cur = '0;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          n_tests = 0;
  int          n_fail  = 0;

  timer_cmp_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(12'h100)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .tim_paddr      (tim_paddr),
    .tim_pwdata     (tim_pwdata),
    .tim_pstrb      (tim_pstrb),
    .tim_prdata     (tim_prdata),
    .cnt_val        (cnt_val),
    .reg_error_flag (reg_error_flag),
    .ch_int         (ch_int),
    .tim_int        (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [11:0] ra(input int ch, input int off);
    return 12'(32'h100 + ch * 32 + off);
  endfunction

  task automatic push_exp(input int kind, input logic [31:0] val, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge sys_clk); #1;
    cnt_val = cnt_cur;
    wr_en = 1'b0; rd_en = 1'b0; probe = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic exp_err, input string nm);
    push_exp(K_ERR, {31'd0, exp_err}, nm);
    @(posedge sys_clk); #1;
    cnt_val = cnt_cur;
    wr_en = 1'b1; rd_en = 1'b0; probe = 1'b0;
    tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp_val, input string nm);
    push_exp(K_RD, exp_val, nm);
    @(posedge sys_clk); #1;
    cnt_val = cnt_cur;
    wr_en = 1'b0; rd_en = 1'b1; probe = 1'b0;
    tim_paddr = a;
  endtask

  task automatic chk_int(input logic [31:0] exp_val, input string nm);
    push_exp(K_INT, exp_val, nm);
    @(posedge sys_clk); #1;
    cnt_val = cnt_cur;
    wr_en = 1'b0; rd_en = 1'b0; probe = 1'b1;
  endtask

  // Monitor: one comparison per presented transaction.
  always @(negedge sys_clk) begin
    if (wr_en || rd_en || probe) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: DUT output with no expected entry (wr=%0b rd=%0b probe=%0b)",
                 wr_en, rd_en, probe);
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.kind)
          K_ERR:   mon_act = {31'd0, reg_error_flag};
          K_RD:    mon_act = tim_prdata;
          default: mon_act = 32'({tim_int, ch_int});
        endcase
        if (mon_act !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.val);
        end else begin
          $display("[TB] %s: 0x%08h ok", mon_e.name, mon_act);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Reset state
    rd(ra(0, 'h00), 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(ra(0, 'h04), 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(ra(0, 'h08), 32'h0, "rst_per");
    rd(ra(0, 'h0C), 32'h0, "rst_ctrl");
    rd(ra(0, 'h10), 32'h0, "rst_stat");
    chk_int(32'h0, "rst_int");
    rd(12'h0F0, 32'h0, "rst_summary");

    // Ch0 one-shot at 0x10
    cnt_cur = 64'd0;
    wr(ra(0, 'h00), 32'h10, 4'hF, 1'b0, "c0_wr_cmp_lo");
    wr(ra(0, 'h04), 32'h0, 4'hF, 1'b0, "c0_wr_cmp_hi");
    wr(ra(0, 'h0C), 32'h3, 4'hF, 1'b0, "c0_wr_ctrl");
    for (int c = 0; c < 16; c++) begin
      cnt_cur = 64'(c);
      idle();
    end
    cnt_cur = 64'h10;
    chk_int(32'h00, "c0_int_event_cycle");
    cnt_cur = 64'h11;
    chk_int(32'h11, "c0_int_after_event");
    rd(ra(0, 'h0C), 32'h2, "c0_ctrl_en_cleared");
    rd(ra(0, 'h10), 32'h1, "c0_stat");
    wr(ra(0, 'h10), 32'h1, 4'h1, 1'b0, "c0_w1c");
    cnt_cur = 64'h10;
    idle();
    cnt_cur = 64'h11;
    rd(ra(0, 'h10), 32'h0, "c0_no_refire");
    chk_int(32'h00, "c0_int_cleared");

    // Ch1 periodic 0x20 step 0x10, counter held 4 cycles per value
    cnt_cur = 64'd0;
    wr(ra(1, 'h00), 32'h20, 4'hF, 1'b0, "c1_wr_cmp_lo");
    wr(ra(1, 'h04), 32'h0, 4'hF, 1'b0, "c1_wr_cmp_hi");
    wr(ra(1, 'h08), 32'h10, 4'hF, 1'b0, "c1_wr_per");
    wr(ra(1, 'h0C), 32'h7, 4'hF, 1'b0, "c1_wr_ctrl");
    for (int v = 'h1F; v <= 'h41; v++) begin
      for (int k = 0; k < 4; k++) begin
        cnt_cur = 64'(v);
        if (v == 'h21 && k == 0)      rd(ra(1, 'h00), 32'h30, "c1_reload_once");
        else if (v == 'h21 && k == 1) rd(ra(1, 'h10), 32'h1, "c1_stat_first");
        else                          idle();
      end
    end
    rd(ra(1, 'h00), 32'h50, "c1_cmp_lo_final");
    rd(ra(1, 'h04), 32'h0, "c1_cmp_hi_final");
    rd(ra(1, 'h10), 32'h3, "c1_missed");
    chk_int(32'h12, "c1_int");

    // Ch2 periodic 64-bit wrap
    cnt_cur = 64'd0;
    wr(ra(2, 'h00), 32'hFFFF_FFF8, 4'hF, 1'b0, "c2_wr_cmp_lo");
    wr(ra(2, 'h08), 32'h10, 4'hF, 1'b0, "c2_wr_per");
    wr(ra(2, 'h0C), 32'h5, 4'hF, 1'b0, "c2_wr_ctrl");
    cnt_cur = 64'hFFFF_FFFF_FFFF_FFF8;
    idle();
    cnt_cur = 64'd0;
    rd(ra(2, 'h04), 32'h0, "c2_wrap_hi");
    rd(ra(2, 'h00), 32'h8, "c2_wrap_lo");
    rd(ra(2, 'h10), 32'h1, "c2_stat");
    chk_int(32'h12, "c2_masked");
    wr(ra(2, 'h0C), 32'h7, 4'hF, 1'b0, "c2_int_en");
    chk_int(32'h16, "c2_int_pending");

    // Ch3: enabling while the counter already sits on CMP must not fire
    cnt_cur = 64'd5;
    wr(ra(3, 'h00), 32'h5, 4'hF, 1'b0, "c3_wr_cmp_lo");
    wr(ra(3, 'h04), 32'h0, 4'hF, 1'b0, "c3_wr_cmp_hi");
    wr(ra(3, 'h0C), 32'h3, 4'hF, 1'b0, "c3_wr_ctrl");
    idle();
    idle();
    rd(ra(3, 'h10), 32'h0, "c3_no_event_held");
    cnt_cur = 64'd6;
    idle();
    cnt_cur = 64'd5;
    idle();
    rd(ra(3, 'h10), 32'h1, "c3_event_rise");
    rd(ra(3, 'h0C), 32'h2, "c3_oneshot_off");
    chk_int(32'h1E, "c3_int");

    // W1C in event cycle: set wins, missed not set
    cnt_cur = 64'h50;
    wr(ra(1, 'h10), 32'h3, 4'h1, 1'b0, "c1_w1c_evt");
    cnt_cur = 64'd0;
    rd(ra(1, 'h10), 32'h1, "c1_set_wins");
    rd(ra(1, 'h00), 32'h60, "c1_reload_4");
    wr(ra(1, 'h10), 32'h3, 4'h2, 1'b0, "c1_w1c_nostrb");
    rd(ra(1, 'h10), 32'h1, "c1_w1c_ignored");

    // CMP write in event cycle suppresses the reload
    cnt_cur = 64'h60;
    wr(ra(1, 'h00), 32'hAABB_CC99, 4'h1, 1'b0, "c1_cmp_wr_evt");
    cnt_cur = 64'd0;
    rd(ra(1, 'h00), 32'h99, "c1_cmp_lo_sw");
    rd(ra(1, 'h04), 32'h0, "c1_cmp_hi_kept");
    rd(ra(1, 'h10), 32'h3, "c1_missed_again");

    // Errors
    wr(ra(1, 'h08), 32'h0, 4'hF, 1'b1, "err_per_zero");
    rd(ra(1, 'h08), 32'h10, "per_unchanged");
    wr(ra(0, 'h0C), 32'h5, 4'hF, 1'b1, "err_ctrl_per0");
    rd(ra(0, 'h0C), 32'h2, "ctrl_unchanged");
    wr(ra(4, 'h00), 32'h1234, 4'hF, 1'b1, "err_ch_range");
    rd(ra(4, 'h00), 32'h0, "rd_ch_range");
    wr(ra(0, 'h14), 32'h1, 4'hF, 1'b1, "err_off14");
    rd(ra(0, 'h14), 32'h0, "rd_off14");
    wr(12'h0F0, 32'hFF, 4'hF, 1'b0, "sum_wr_no_err");
    rd(12'h0F0, 32'hE, "summary");

    // Asynchronous reset mid-run
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; probe = 1'b0;
    chk_int(32'h0, "arst_int");
    rd(ra(1, 'h00), 32'hFFFF_FFFF, "arst_cmp_lo");
    rd(ra(1, 'h04), 32'hFFFF_FFFF, "arst_cmp_hi");
    rd(ra(1, 'h10), 32'h0, "arst_stat");
    rd(12'h0F0, 32'h0, "arst_summary");
    idle();
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    cnt_cur = 64'hFFFF_FFFF_FFFF_FFFF;
    chk_int(32'h0, "post_rst_int");
    rd(ra(1, 'h0C), 32'h0, "post_rst_ctrl");
    idle();
    idle();

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_cmp_bank.md
# timer_cmp_bank

Parametrised multi-channel compare/interrupt bank attached to the timer's 64-bit counter. It supersedes the single compare/interrupt pair with `NUM_CH` independent channels. Each channel has one-shot or periodic (auto-reload) mode, a sticky W1C status and an overrun ("missed") flag. The bank sits beside the timer register set on the same decoded APB write/read strobes and drives per-channel and combined interrupt lines.

## Interface
- `NUM_CH`, 4: number of compare channels, legal 1..8.
- `BASE_ADDR`, 12'h100: byte address of channel 0 window. Channel n window = `BASE_ADDR + n*0x20`.
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: APB write strobe, one cycle per access.
- `rd_en` in 1: APB read strobe. Reads have no side effects.
- `tim_paddr` in 12: byte address.
- `tim_pwdata` in 32: write data.
- `tim_pstrb` in 4: byte strobes.
- `tim_prdata` out 32: read data, combinational from `tim_paddr`.
- `cnt_val` in 64: live counter value.
- `reg_error_flag` out 1: combinational; high during an illegal write.
- `ch_int` out NUM_CH: per-channel interrupt = status & int_en.
- `tim_int` out 1: OR of `ch_int`.

## Operation
- Per-channel registers, as offsets within the channel window:
  - 0x00 CMP_LO.
  - 0x04 CMP_HI.
  - 0x08 PER: 32-bit reload period.
  - 0x0C CTRL: bit0 en, bit1 int_en, bit2 mode (0 one-shot, 1 periodic).
  - 0x10 STAT: bit0 status, bit1 missed. Both W1C. Write 0 has no effect.
- Summary register at `BASE_ADDR-0x10`: read-only, bits[NUM_CH-1:0] = status of each channel. Writes to it are ignored and raise no error.
- Byte strobes apply to CMP/PER/CTRL. STAT W1C is honoured only when `tim_pstrb[0]=1`. Unused bits read 0.
- Match detection:
  - match_n = (`cnt_val` == {CMP_HI,CMP_LO}).
  - match_q_n registers match_n every cycle, regardless of en.
  - event_n = en & match_n & ~match_q_n. A counter held by the prescaler produces exactly one event.
- On event_n:
  - status=1.
  - If status was already 1, missed=1.
  - mode=0: en cleared (one-shot self-disable).
  - mode=1: CMP ← CMP + zero-extended PER, modulo 2^64. Carry propagates into CMP_HI; wrap past all-ones is legal.
- Simultaneous events:
  - W1C clear of status in the event cycle: status stays 1 (set wins) and missed is not set. Same rule for missed.
  - SW write to CMP_LO or CMP_HI of a channel in its event cycle: the reload is suppressed for both halves. Written bytes take `tim_pwdata`; all other bytes keep their pre-event value.
  - SW write to CTRL in the event cycle: the SW value wins, including en.
- Errors: `reg_error_flag`=1 when `wr_en` and any of the following. An errored write has no effect on any register.
  - Address falls in the channel windows but the channel index ≥ NUM_CH.
  - Offset is 0x14..0x1C.
  - Resulting CTRL has en=1, mode=1 and current PER==0.
  - PER write would make PER 0 while en=1 and mode=1.
- Reads of unmapped addresses return 0 with no error.

## Timing
- Reset values:
  - CMP = all-ones, PER=0, CTRL=0, status=0, missed=0, match_q=0.
  - `ch_int`=0, `tim_int`=0, `tim_prdata` reflects the reset registers.
- Writes take effect at the `sys_clk` edge that samples `wr_en`. Readback is valid the next cycle.
- Latency:
  - Event in cycle T (cnt_val==CMP, match_q=0): status, missed, reload and one-shot en clear all update at the end of T.
  - `ch_int`/`tim_int` are high from cycle T+1.
- `int_en` change reaches `ch_int` the cycle after the write. Pending status is preserved.
- Asynchronous reset mid-operation clears all state immediately. No event is generated on the first post-reset cycle unless match rises after it.

## Test plan
- Ch0 one-shot, CMP=0x10, int_en=1, counter increments from 0 → status=1 and `ch_int[0]`/`tim_int` high from cycle after cnt=0x10; CTRL.en reads 0; no further events.
- Ch1 periodic, CMP=0x20, PER=0x10 → events at cnt 0x20, 0x30, 0x40; CMP reads 0x50 after third; counter held 4 cycles per value yields one event per match.
- Ch2 periodic, CMP=0xFFFF_FFFF_FFFF_FFF8, PER=0x10 → after event CMP_HI=0, CMP_LO=0x8 (64-bit wrap).
- Status still 1 at second event → missed=1; W1C 0x3 in same cycle as an event → status=1, missed=0.
- Write CTRL en=1, mode=1 with PER=0 → `reg_error_flag`=1, CTRL unchanged. Write to channel NUM_CH window → error. Read offset 0x14 → 0 with no error.
- Assert `sys_rst_n` low mid-run with status set → all outputs 0, CMP all-ones on readback.
